// File: rtl/regfile_sb_if.sv
// regfile_sb_if: writeback, decode-read and issue signals between the pipeline and regfile_sb
interface regfile_sb_if;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_we;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_use;
    logic        rt_use;
    logic        issue_we;
    logic [4:0]  issue_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        sb_err;

    modport master (
        output wb_data, wb_addr, wb_we, rs_addr, rt_addr, rs_use, rt_use, issue_we, issue_addr,
        input  rs_data, rt_data, stall, sb_err
    );

    modport slave (
        input  wb_data, wb_addr, wb_we, rs_addr, rt_addr, rs_use, rt_use, issue_we, issue_addr,
        output rs_data, rt_data, stall, sb_err
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 32x32 register file with per-register pending-write scoreboard; REGFILE_BYPASS_EN enables wb-to-read forwarding
module regfile_sb #(
    parameter int NREG    = 32,
    parameter int MAXPEND = 3
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    logic [31:0] regs [NREG];
    logic [1:0]  pend [NREG];
    logic        sb_err_q;
    logic        wb_nz;
    logic        inc;
    logic        dec;
    logic        byp_rs;
    logic        byp_rt;
    logic        hz_rs;
    logic        hz_rt;
    logic        full;

    assign wb_nz = bus.wb_we && bus.wb_addr != 5'd0;
    assign dec   = wb_nz && pend[bus.wb_addr] != 2'd0;
    assign inc   = bus.issue_we && !bus.stall && bus.issue_addr != 5'd0;

    // Hazard detection, forwarding and operand selection
    always_comb begin
`ifdef REGFILE_BYPASS_EN
        byp_rs      = wb_nz && bus.wb_addr == bus.rs_addr && pend[bus.rs_addr] == 2'd1;
        byp_rt      = wb_nz && bus.wb_addr == bus.rt_addr && pend[bus.rt_addr] == 2'd1;
        bus.rs_data = (wb_nz && bus.wb_addr == bus.rs_addr) ? bus.wb_data : regs[bus.rs_addr];
        bus.rt_data = (wb_nz && bus.wb_addr == bus.rt_addr) ? bus.wb_data : regs[bus.rt_addr];
`else
        byp_rs      = 1'b0;
        byp_rt      = 1'b0;
        bus.rs_data = regs[bus.rs_addr];
        bus.rt_data = regs[bus.rt_addr];
`endif
        hz_rs      = bus.rs_use && pend[bus.rs_addr] != 2'd0 && !byp_rs;
        hz_rt      = bus.rt_use && pend[bus.rt_addr] != 2'd0 && !byp_rt;
        full       = bus.issue_we && pend[bus.issue_addr] == 2'(MAXPEND) && !(dec && bus.wb_addr == bus.issue_addr);
        bus.stall  = hz_rs || hz_rt || full;
        bus.sb_err = sb_err_q;
    end

    // Commit writebacks; register 0 is never written so it always reads 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_nz) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Pending counters: issue increments, matching writeback decrements, both together cancel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) pend[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (inc && bus.issue_addr == 5'(i) && !(dec && bus.wb_addr == 5'(i)))
                    pend[i] <= pend[i] + 2'd1;
                else if (dec && bus.wb_addr == 5'(i) && !(inc && bus.issue_addr == 5'(i)))
                    pend[i] <= pend[i] - 2'd1;
            end
        end
    end

    // Sticky flag for a writeback to a register with no write in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sb_err_q <= 1'b0;
        else if (wb_nz && pend[bus.wb_addr] == 2'd0)
            sb_err_q <= 1'b1;
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed scoreboard bench for regfile_sb against an array/counter reference model
module tb_regfile_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_sb_if bus();
    regfile_sb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        st;
        logic        err;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mem [32];
    int          pend_m [32];
    bit          err_m;
    int          checks = 0;
    int          errors = 0;

    // Monitor: one expected response per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (bus.rs_data !== e.rs || bus.rt_data !== e.rt || bus.stall !== e.st || bus.sb_err !== e.err) begin
                errors++;
                $display("FAIL %s: got rs=%h rt=%h stall=%b sb_err=%b, want rs=%h rt=%h stall=%b sb_err=%b",
                         e.name, bus.rs_data, bus.rt_data, bus.stall, bus.sb_err, e.rs, e.rt, e.st, e.err);
            end
        end
    end

    function automatic bit busy(input logic use_, input logic [4:0] a, input logic we, input logic [4:0] wa);
        return use_ && pend_m[a] > 0 && !(BYP && pend_m[a] == 1 && we && wa == a);
    endfunction

    function automatic logic [31:0] rd(input logic [4:0] a, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        return (BYP && we && wa == a && a != 0) ? wd : mem[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            pend_m[i] = 0;
        end
        err_m = 1'b0;
    endtask

    task automatic step(input string name, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] tb, input logic ru, input logic tu,
                        input logic iw, input logic [4:0] ia);
        exp_t e;
        bit   st;
        bus.wb_we = we; bus.wb_addr = wa; bus.wb_data = wd;
        bus.rs_addr = ra; bus.rt_addr = tb; bus.rs_use = ru; bus.rt_use = tu;
        bus.issue_we = iw; bus.issue_addr = ia;
        st = busy(ru, ra, we, wa) || busy(tu, tb, we, wa) ||
             (iw && pend_m[ia] == 3 && !(we && wa == ia));
        e.name = name;
        e.rs = rd(ra, we, wa, wd);
        e.rt = rd(tb, we, wa, wd);
        e.st = st;
        e.err = err_m;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (rst_n) begin
            if (we && wa != 0) begin
                mem[wa] = wd;
                if (pend_m[wa] > 0) pend_m[wa]--;
                else err_m = 1'b1;
            end
            if (iw && !st && ia != 0) pend_m[ia]++;
        end
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        clear_model();
        for (int i = 0; i < n; i++)
            step("reset_rd", 0, 0, 0, 5'(i), 5'(31 - i), 1, 1, 0, 0);
        rst_n = 1'b1;
        step("post_reset", 0, 0, 0, 5'd3, 5'd9, 1, 1, 0, 0);
    endtask

    initial begin
        clear_model();
        bus.wb_we = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.rs_addr = 0; bus.rt_addr = 0;
        bus.rs_use = 0; bus.rt_use = 0; bus.issue_we = 0; bus.issue_addr = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++)
            step("pre_wr", 1, 5'($urandom_range(1, 31)), $urandom, 5'($urandom), 5'($urandom), 0, 0, 0, 0);
        do_reset(32);

        step("wr5", 1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0, 0, 0, 0, 0);
        step("rd5", 0, 5'd0, 0, 5'd5, 5'd0, 1, 0, 0, 0);
        step("wr0", 1, 5'd0, 32'h12345678, 5'd5, 5'd0, 0, 0, 0, 0);
        step("rd0", 0, 5'd0, 0, 5'd0, 5'd5, 1, 1, 0, 0);
        do_reset(2);

        step("raw_iss8", 0, 0, 0, 0, 0, 0, 0, 1, 5'd8);
        step("raw_wait1", 0, 0, 0, 5'd8, 0, 1, 0, 0, 0);
        step("raw_wait2", 0, 0, 0, 5'd8, 0, 1, 0, 0, 0);
        step("raw_wb8", 1, 5'd8, 32'hA5A5A5A5, 5'd8, 5'd8, 1, 1, 0, 0);
        step("raw_after", 0, 0, 0, 5'd8, 5'd8, 1, 1, 0, 0);

        step("sat_iss1", 0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
        step("sat_iss2", 0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
        step("sat_iss3", 0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
        step("sat_full", 0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
        step("sat_wb_iss", 1, 5'd9, 32'h99, 0, 0, 0, 0, 1, 5'd9);
        step("sat_still", 0, 0, 0, 0, 0, 0, 0, 1, 5'd9);
        for (int i = 0; i < 3; i++)
            step("sat_drain", 1, 5'd9, 32'h100 + 32'(i), 5'd9, 0, 1, 0, 0, 0);
        step("sat_empty", 0, 0, 0, 5'd9, 0, 1, 0, 0, 0);

        step("r4_iss", 0, 0, 0, 0, 0, 0, 0, 1, 5'd4);
        step("r4_iss_wb", 1, 5'd4, 32'h44, 0, 0, 0, 0, 1, 5'd4);
        step("r4_rd", 0, 0, 0, 5'd4, 5'd4, 1, 1, 0, 0);
        step("r4_wb", 1, 5'd4, 32'h4444, 0, 5'd4, 0, 1, 0, 0);
        step("r4_done", 0, 0, 0, 5'd4, 0, 1, 0, 0, 0);

        step("spur_wb7", 1, 5'd7, 32'h77777777, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            step("spur_sticky", 0, 0, 0, 5'd7, 0, 1, 0, 0, 0);
        do_reset(1);

        for (int i = 0; i < 400; i++)
            step("rand", $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                 $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)));
        do_reset(2);

        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
